// File: rtl/evm_multi.sv
// Parametrised EVM controller: one-hot ballots, per-candidate tallies, sequential winner/tie scan.
// Latency: one ballot per WAIT_VOTE->VOTED pair; results valid NUM_CAND cycles after the poll closes.
// No backpressure: inputs are level-sampled each cycle. Define EVM_SATURATE_EN for saturating counters.
module evm_multi #(
    parameter int NUM_CAND = 4,
    parameter int WIDTH    = 8,
    parameter int TIMEOUT  = 100,
    parameter int TMR_W    = 7,
    parameter int NAME_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                switch_on_evm,
    input  logic                candidate_ready,
    input  logic [NUM_CAND-1:0] vote,
    input  logic                voting_session_done,
    input  logic [NAME_W-1:0]   display_sel,
    input  logic                display_winner,
    output logic [NAME_W-1:0]   candidate_name,
    output logic [WIDTH-1:0]    results,
    output logic                invalid_results,
    output logic                voting_in_progress,
    output logic                voting_done,
    output logic                vote_rejected,
    output logic                overflow
);

    typedef enum logic [2:0] {
        IDLE, WAIT_CAND, WAIT_VOTE, VOTED, TALLY, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  cnt [NUM_CAND];
    logic [TMR_W-1:0]  timer;
    logic [NAME_W-1:0] vote_idx, scan_idx, max_idx;
    logic [WIDTH-1:0]  max_cnt, scan_cnt, sel_cnt;
    logic              tie, rej_q;
    logic              vote_any, vote_multi, timer_hit;
    logic [NAME_W-1:0] vote_enc;

    // x & (x-1) is nonzero exactly when more than one bit is set
    always_comb begin
        vote_any   = |vote;
        vote_multi = (vote & (vote - NUM_CAND'(1))) != '0;
        vote_enc   = '0;
        for (int i = 0; i < NUM_CAND; i++)
            if (vote[i]) vote_enc = NAME_W'(i);
    end

    assign timer_hit = (timer == TMR_W'(TIMEOUT));

    always_comb begin
        scan_cnt = '0;
        sel_cnt  = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (scan_idx == NAME_W'(i))    scan_cnt = cnt[i];
            if (display_sel == NAME_W'(i)) sel_cnt  = cnt[i];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (switch_on_evm) state_nxt = WAIT_CAND;
            WAIT_CAND: begin
                if (candidate_ready)                       state_nxt = WAIT_VOTE;
                else if (voting_session_done || timer_hit) state_nxt = TALLY;
            end
            WAIT_VOTE: begin
                if (vote_multi)                            state_nxt = WAIT_VOTE;
                else if (vote_any && !candidate_ready)     state_nxt = VOTED;
                else if (!vote_any && timer_hit)           state_nxt = WAIT_CAND;
            end
            VOTED:     state_nxt = candidate_ready ? WAIT_VOTE : WAIT_CAND;
            TALLY:     if (scan_idx == NAME_W'(NUM_CAND - 1)) state_nxt = DONE;
            DONE:      state_nxt = DONE;
            default:   state_nxt = IDLE;
        endcase
        if (!switch_on_evm) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Inactivity timer: restarts on state entry and on any ballot activity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (!switch_on_evm || state_nxt != state ||
                     !(state == WAIT_CAND || state == WAIT_VOTE)) begin
            timer <= '0;
        end else if (state == WAIT_VOTE && vote_any) begin
            timer <= '0;
        end else if (!timer_hit) begin
            timer <= timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vote_idx <= '0;
            rej_q    <= 1'b0;
        end else begin
            rej_q <= switch_on_evm && state == WAIT_VOTE && vote_multi;
            if (state == WAIT_VOTE && state_nxt == VOTED) vote_idx <= vote_enc;
        end
    end

`ifdef EVM_SATURATE_EN
    logic ovf_q;
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
`ifdef EVM_SATURATE_EN
            ovf_q <= 1'b0;
`endif
        end else if (!switch_on_evm || state == IDLE) begin
            for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
`ifdef EVM_SATURATE_EN
            ovf_q <= 1'b0;
`endif
        end else if (state == VOTED) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (vote_idx == NAME_W'(i)) begin
`ifdef EVM_SATURATE_EN
                    if (cnt[i] == '1) ovf_q  <= 1'b1;
                    else              cnt[i] <= cnt[i] + WIDTH'(1);
`else
                    cnt[i] <= cnt[i] + WIDTH'(1);
`endif
                end
            end
        end
    end

    // Scan: index 0 seeds the maximum; an equal count later marks a tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_idx <= '0;
            max_cnt  <= '0;
            max_idx  <= '0;
            tie      <= 1'b0;
        end else if (!switch_on_evm || state == IDLE) begin
            scan_idx <= '0;
            max_cnt  <= '0;
            max_idx  <= '0;
            tie      <= 1'b0;
        end else if (state == TALLY) begin
            scan_idx <= scan_idx + NAME_W'(1);
            if (scan_idx == '0) begin
                max_cnt <= scan_cnt;
                max_idx <= '0;
                tie     <= 1'b0;
            end else if (scan_cnt > max_cnt) begin
                max_cnt <= scan_cnt;
                max_idx <= scan_idx;
                tie     <= 1'b0;
            end else if (scan_cnt == max_cnt) begin
                tie     <= 1'b1;
            end
        end else begin
            scan_idx <= '0;
        end
    end

    always_comb begin
        candidate_name     = '0;
        results            = '0;
        invalid_results    = 1'b0;
        voting_done        = 1'b0;
        voting_in_progress = (state == WAIT_VOTE);
        vote_rejected      = rej_q;
        if (state == DONE) begin
            voting_done     = 1'b1;
            invalid_results = tie;
            if (display_winner) begin
                if (!tie) begin
                    candidate_name = max_idx + NAME_W'(1);
                    results        = max_cnt;
                end
            end else if (display_sel < NAME_W'(NUM_CAND)) begin
                candidate_name = display_sel + NAME_W'(1);
                results        = sel_cnt;
            end
        end
    end

endmodule

// File: doc/evm_multi.md
Name: evm_multi

Overview:
- Parametrised successor to the team's 3-candidate EVM controller: NUM_CAND candidates, configurable count width and inactivity timeout.
- Votes arrive on a one-hot vector; per-candidate tallies are kept in a counter array.
- A sequential tally scan picks the winner and detects ties before results are released.
- Sits between the ballot-unit button debouncers and the results display/readout logic.

Parameters:
- NUM_CAND, 4: number of candidates, 2..15.
- WIDTH, 8: width of each vote counter and of results.
- TIMEOUT, 100: idle cycles before timeout; must be >= 1.
- TMR_W, 7: timer width; must satisfy 2^TMR_W > TIMEOUT.
- NAME_W, 3: candidate_name width; must satisfy 2^NAME_W > NUM_CAND.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- switch_on_evm  in  1  EVM power switch; low acts as a synchronous clear.
- candidate_ready  in  1  presiding officer enables one ballot.
- vote  in  NUM_CAND  ballot buttons; bit i is candidate i+1.
- voting_session_done  in  1  close the poll.
- display_sel  in  NAME_W  candidate index (0-based) to read out.
- display_winner  in  1  1 = show winner, 0 = show display_sel.
- candidate_name  out  NAME_W  1-based candidate id; 0 = none.
- results  out  WIDTH  displayed vote count.
- invalid_results  out  1  tie for top count.
- voting_in_progress  out  1  high in WAIT_VOTE.
- voting_done  out  1  high in DONE.
- vote_rejected  out  1  one-cycle pulse on a multi-hot vote.
- overflow  out  1  sticky counter overflow (see Optional Feature).

Behaviour:

States and transitions (current-state register):
- IDLE → WAIT_CAND when switch_on_evm=1. On this transition, clear all counters and flags.
- WAIT_CAND, priority order:
  - candidate_ready → WAIT_VOTE.
  - else voting_session_done → TALLY.
  - else timer == TIMEOUT → TALLY.
- WAIT_VOTE:
  - Exactly one vote bit set and candidate_ready=0: latch the index, go to VOTED.
  - More than one bit set: pulse vote_rejected for one cycle, stay, reset the timer.
  - vote=0: after TIMEOUT idle cycles, go to WAIT_CAND. No vote is recorded.
- VOTED (one cycle): increment counter[latched index], then:
  - candidate_ready=1 → WAIT_VOTE.
  - otherwise → WAIT_CAND.
- TALLY: scan one candidate per cycle, index 0..NUM_CAND-1, so exactly NUM_CAND cycles.
  - Track max_cnt, max_idx, tie.
  - A strictly greater count replaces max and clears tie.
  - An equal count sets tie.
  - Index 0 initialises max. On scan end → DONE.
- DONE: hold until switch_on_evm=0.

Timer:
- Counts only in WAIT_CAND and WAIT_VOTE.
- Clears on state entry, on candidate_ready (WAIT_CAND), and on any nonzero vote (WAIT_VOTE).
- Saturates at TIMEOUT.

switch_on_evm=0, any state:
- Next cycle is IDLE.
- Counters, timer, scan registers, winner registers and overflow are all cleared.
- A vote in VOTED during that cycle is discarded.

rst=0:
- Immediate asynchronous clear of all state, equivalent to the above.
- All outputs are 0 during reset.

Outputs (combinational from state and registers):
- Zero outside DONE, except voting_in_progress (high in WAIT_VOTE) and vote_rejected.
- In DONE:
  - voting_done=1.
  - invalid_results=tie. An all-zero tally counts as a tie.
  - display_winner=1 and tie=0: candidate_name=max_idx+1, results=max_cnt.
  - display_winner=1 and tie=1: candidate_name=0, results=0.
  - display_winner=0: candidate_name=display_sel+1, results=counter[display_sel]. This is shown even when tie=1.
  - display_sel >= NUM_CAND: both outputs 0.

Optional Feature:
- Macro EVM_SATURATE_EN.
- Defined:
  - A counter at 2^WIDTH-1 holds on increment.
  - overflow is set and stays set until switch-off or reset.
- Undefined:
  - Counters wrap modulo 2^WIDTH.
  - overflow is tied 0.

Test Plan:
- Reset, switch on; 3 ballots for candidate 2, 1 for candidate 4; session_done → after 4 TALLY cycles: voting_done=1, winner name=2, results=3, invalid=0; display_sel=3 → name=4, results=1.
- Ballot with vote=4'b0101 → vote_rejected pulses 1 cycle, state stays WAIT_VOTE; then vote=4'b0001 → counter[0]=1.
- candidate_ready then no vote for 100 cycles → WAIT_CAND, no count change; 100 further idle cycles → TALLY → DONE; all-zero tally gives invalid_results=1, winner name=0.
- 2 votes each for candidates 1 and 3 → invalid_results=1; winner display gives 0/0; display_sel=2 still gives name=3, results=2.
- WIDTH=2, 4 votes for candidate 1: with EVM_SATURATE_EN, count=3 and overflow=1; without it, count=0 and overflow=0.
- switch_on_evm dropped mid-VOTED → IDLE next cycle; after switch-on, all counters=0 and outputs=0.
